// File: rtl/imm_ext_pkg.sv
// Shared types and helpers for the immediate extender.
// Contents:
//   ext_mode_t   - extension mode encoding (SIGN, ZERO, UPPER, BRANCH)
//   IMM_IN_W     - default raw immediate width
//   IMM_OUT_W    - default extended immediate width
//   ext_compute  - width-generic reference extension, result in the low out_w bits
package imm_ext_pkg;

   localparam int unsigned IMM_IN_W  = 16;
   localparam int unsigned IMM_OUT_W = 32;
   localparam int unsigned IMM_MAX_W = 64;

   typedef enum logic [1:0] {
      EXT_SIGN   = 2'd0,
      EXT_ZERO   = 2'd1,
      EXT_UPPER  = 2'd2,
      EXT_BRANCH = 2'd3
   } ext_mode_t;

   // Extends the low in_w bits of imm to out_w bits. Widths up to 64 bits.
   // Bits above out_w in the return value are always zero.
   function automatic logic [IMM_MAX_W-1:0] ext_compute(
      input logic [IMM_MAX_W-1:0] imm,
      input ext_mode_t            mode,
      input int unsigned          in_w     = IMM_IN_W,
      input int unsigned          out_w    = IMM_OUT_W,
      input int unsigned          br_shift = 2
   );
      logic [IMM_MAX_W-1:0] mask_in;
      logic [IMM_MAX_W-1:0] mask_out;
      logic [IMM_MAX_W-1:0] raw;
      logic [IMM_MAX_W-1:0] sext;
      logic [IMM_MAX_W-1:0] res;
      logic                 sign_bit;

      mask_in  = (64'd1 << in_w) - 64'd1;
      mask_out = (out_w >= IMM_MAX_W) ? {IMM_MAX_W{1'b1}} : ((64'd1 << out_w) - 64'd1);
      raw      = imm & mask_in;
      sign_bit = imm[in_w-1];
      sext     = sign_bit ? ((raw | ~mask_in) & mask_out) : raw;

      case (mode)
         EXT_SIGN:   res = sext;
         EXT_ZERO:   res = raw;
         EXT_UPPER:  res = (raw << (out_w - in_w)) & mask_out;
         EXT_BRANCH: res = (sext << br_shift) & mask_out;
         default:    res = '0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/imm_ext_fifo2.sv
// Generic 2-entry FIFO with valid/ready on both sides.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   wr_valid/ready  - write handshake; wr_ready has no path from rd_ready
//   wr_data         - W-bit write payload
//   rd_valid/ready  - read handshake; rd_valid = (count != 0)
//   rd_data         - head entry, stable while rd_valid & !rd_ready
module imm_ext_fifo2
   import imm_ext_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         wr_valid,
   output logic         wr_ready,
   input  logic [W-1:0] wr_data,
   output logic         rd_valid,
   input  logic         rd_ready,
   output logic [W-1:0] rd_data
);

   logic [W-1:0] mem [2];
   logic         wr_ptr;
   logic         rd_ptr;
   logic [1:0]   count;
   logic         push;
   logic         pop;

   // Ready is held low during reset so nothing is accepted into a clearing buffer.
   assign wr_ready = !rst && (count != 2'd2);
   assign rd_valid = (count != 2'd0);
   assign rd_data  = mem[rd_ptr];
   assign push     = wr_valid & wr_ready;
   assign pop      = rd_valid & rd_ready;

   // Storage, pointers and occupancy; storage is cleared so outputs read zero after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= wr_data;
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/imm_ext_pipe.sv
// Mode-selectable immediate extender with a 2-entry result buffer.
// Optional macro IMM_EXT_PERF_EN adds perf_cnt (pops) and perf_stall
// (cycles with out_valid & !out_ready), both 32-bit wrapping counters.
// Ports:
//   clk, rst                 - clock, synchronous active-high reset
//   in_valid/in_ready        - input handshake
//   in_imm, in_mode, in_tag  - raw immediate, extension mode, sideband tag
//   out_valid/out_ready      - output handshake
//   out_data, out_tag        - extended immediate and its tag
//   out_neg                  - top bit of the original raw immediate
module imm_ext_pipe
   import imm_ext_pkg::*;
#(
   parameter int unsigned IN_W     = IMM_IN_W,
   parameter int unsigned OUT_W    = IMM_OUT_W,
   parameter int unsigned TAG_W    = 4,
   parameter int unsigned BR_SHIFT = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [IN_W-1:0]  in_imm,
   input  logic [1:0]       in_mode,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [OUT_W-1:0] out_data,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_neg
`ifdef IMM_EXT_PERF_EN
   ,
   output logic [31:0]      perf_cnt,
   output logic [31:0]      perf_stall
`endif
);

   localparam int unsigned BUF_W = OUT_W + TAG_W + 1;

   logic [OUT_W-1:0] ext_data;
   logic [BUF_W-1:0] wr_entry;
   logic [BUF_W-1:0] rd_entry;

   // Extension is purely combinational; only the pushed value reaches state.
   assign ext_data = OUT_W'(ext_compute(IMM_MAX_W'(in_imm), ext_mode_t'(in_mode),
                                        IN_W, OUT_W, BR_SHIFT));
   assign wr_entry = {ext_data, in_tag, in_imm[IN_W-1]};

   imm_ext_fifo2 #(
      .W (BUF_W)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_valid (in_valid),
      .wr_ready (in_ready),
      .wr_data  (wr_entry),
      .rd_valid (out_valid),
      .rd_ready (out_ready),
      .rd_data  (rd_entry)
   );

   assign out_data = rd_entry[BUF_W-1 -: OUT_W];
   assign out_tag  = rd_entry[TAG_W:1];
   assign out_neg  = rd_entry[0];

`ifdef IMM_EXT_PERF_EN
   // Pop and stall counters; wrap naturally at 2^32.
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_cnt   <= 32'd0;
         perf_stall <= 32'd0;
      end else begin
         if (out_valid && out_ready) begin
            perf_cnt <= perf_cnt + 32'd1;
         end
         if (out_valid && !out_ready) begin
            perf_stall <= perf_stall + 32'd1;
         end
      end
   end
`endif

endmodule
